// File: rtl/parking_pkg.sv
// Shared constants and the hourly university-capacity schedule for the campus
// parking controller.
package parking_pkg;

  localparam int DEF_CNT_W          = 10;
  localparam int HOUR_W             = 5;
  localparam int DEF_CLOCKS_IN_HOUR = 500;
  localparam int DEF_START_HOUR     = 8;
  localparam int DEF_HOURS_PER_DAY  = 24;
  localparam int DEF_TOTAL_CAP      = 700;
  localparam int DEF_UNI_CAP_BASE   = 500;
  localparam int DEF_UNI_CAP_STEP   = 50;
  localparam int DEF_UNI_CAP_MIN    = 200;
  localparam int DEF_RAMP_START     = 5;

  // University capacity for hour index h: flat before the ramp, then falling
  // by one step per hour down to the floor.
  function automatic int uni_cap_at(input int h, input int base, input int step,
                                    input int cap_min, input int ramp_start);
    int cap;
    if (h < ramp_start) begin
      cap = base;
    end else begin
      cap = base - step * (h - ramp_start + 32'sd1);
      cap = (cap < cap_min) ? cap_min : cap;
    end
    return cap;
  endfunction

endpackage

// File: rtl/parking_hour_timer.sv
// Time-of-day timer: counts clocks within the hour and the hour index within
// the day. hour_tick / day_wrap flag that the coming clock edge ends the hour / day.
module parking_hour_timer
  import parking_pkg::*;
#(
  parameter int CLOCKS_IN_HOUR = DEF_CLOCKS_IN_HOUR,
  parameter int HOURS_PER_DAY  = DEF_HOURS_PER_DAY
) (
  input  logic              clock,
  input  logic              reset,
  output logic [HOUR_W-1:0] hour_idx,
  output logic              hour_tick,
  output logic              day_wrap
);

  localparam int CYC_W = (CLOCKS_IN_HOUR > 1) ? $clog2(CLOCKS_IN_HOUR) : 1;
  localparam logic [CYC_W-1:0]  CYC_LAST  = CYC_W'(CLOCKS_IN_HOUR - 1);
  localparam logic [HOUR_W-1:0] HOUR_LAST = HOUR_W'(HOURS_PER_DAY - 1);

  logic [CYC_W-1:0]  cyc_d, cyc_q;
  logic [HOUR_W-1:0] hour_d, hour_q;

  // Next-state for the cycle counter and hour index.
  always_comb begin
    hour_tick = (cyc_q == CYC_LAST);
    day_wrap  = hour_tick && (hour_q == HOUR_LAST);
    if (hour_tick) begin
      cyc_d = {CYC_W{1'b0}};
    end else begin
      cyc_d = cyc_q + CYC_W'(1'b1);
    end
    if (day_wrap) begin
      hour_d = {HOUR_W{1'b0}};
    end else if (hour_tick) begin
      hour_d = hour_q + HOUR_W'(1'b1);
    end else begin
      hour_d = hour_q;
    end
  end

  // Timer state registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cyc_q  <= {CYC_W{1'b0}};
      hour_q <= {HOUR_W{1'b0}};
    end else begin
      cyc_q  <= cyc_d;
      hour_q <= hour_d;
    end
  end

  assign hour_idx = hour_q;

endmodule

// File: rtl/parking_ctrl_gen.sv
// Second-generation campus parking controller: per-class occupancy, free space
// from the hourly capacity schedule, reject/fault pulses. Optional PARKING_PEAK_EN
// adds per-day peak occupancy outputs.
module parking_ctrl_gen
  import parking_pkg::*;
#(
  parameter int CLOCKS_IN_HOUR = DEF_CLOCKS_IN_HOUR,
  parameter int START_HOUR     = DEF_START_HOUR,
  parameter int HOURS_PER_DAY  = DEF_HOURS_PER_DAY,
  parameter int TOTAL_CAP      = DEF_TOTAL_CAP,
  parameter int UNI_CAP_BASE   = DEF_UNI_CAP_BASE,
  parameter int UNI_CAP_STEP   = DEF_UNI_CAP_STEP,
  parameter int UNI_CAP_MIN    = DEF_UNI_CAP_MIN,
  parameter int RAMP_START     = DEF_RAMP_START,
  parameter int CNT_W          = DEF_CNT_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              car_entered,
  input  logic              is_uni_car_entered,
  input  logic              car_exited,
  input  logic              is_uni_car_exited,
  output logic [HOUR_W-1:0] hour,
  output logic [CNT_W-1:0]  uni_parked_car,
  output logic [CNT_W-1:0]  parked_car,
  output logic [CNT_W-1:0]  uni_vacated_space,
  output logic [CNT_W-1:0]  vacated_space,
  output logic              uni_is_vacated_space,
  output logic              is_vacated_space,
  output logic              ja_nist,
  output logic              faulty_exit
`ifdef PARKING_PEAK_EN
  ,
  output logic [CNT_W-1:0]  uni_peak,
  output logic [CNT_W-1:0]  gen_peak
`endif
);

  localparam int CAP_W = CNT_W + 4;
  localparam logic [CNT_W-1:0]        CNT_ZERO    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]        CNT_ONE     = CNT_W'(1'b1);
  localparam logic signed [CAP_W-1:0] TOTAL_CAP_S = CAP_W'(TOTAL_CAP);
  localparam logic [CNT_W-1:0]        RST_UNI_VAC = CNT_W'(UNI_CAP_BASE);
  localparam logic [CNT_W-1:0]        RST_GEN_VAC = CNT_W'(TOTAL_CAP - UNI_CAP_BASE);
  localparam logic [HOUR_W-1:0]       START_HOUR_V = HOUR_W'(START_HOUR);

  function automatic logic signed [CAP_W-1:0] cap_of(input logic [HOUR_W-1:0] idx);
    return CAP_W'(uni_cap_at(int'(idx), UNI_CAP_BASE, UNI_CAP_STEP, UNI_CAP_MIN, RAMP_START));
  endfunction

  // Capacity minus occupancy, clamped at zero: shrinking capacity never goes negative.
  function automatic logic [CNT_W-1:0] free_of(input logic signed [CAP_W-1:0] cap,
                                               input logic [CNT_W-1:0] cnt);
    logic signed [CAP_W-1:0] diff;
    diff = cap - $signed({4'b0000, cnt});
    if (diff[CAP_W-1]) begin
      free_of = CNT_ZERO;
    end else begin
      free_of = diff[CNT_W-1:0];
    end
  endfunction

  logic [HOUR_W-1:0]       hour_idx_s, hour_next_s;
  logic                    hour_tick_s, day_wrap_s;
  logic signed [CAP_W-1:0] uni_cap_now_s, gen_cap_now_s, uni_cap_next_s, gen_cap_next_s;

  logic [HOUR_W-1:0] hour_d, hour_q;
  logic [CNT_W-1:0]  uni_parked_d, uni_parked_q, parked_d, parked_q;
  logic [CNT_W-1:0]  uni_vac_d, uni_vac_q, vac_d, vac_q;
  logic              uni_is_vac_d, uni_is_vac_q, is_vac_d, is_vac_q;
  logic              ja_nist_d, ja_nist_q, faulty_exit_d, faulty_exit_q;

  parking_hour_timer #(
    .CLOCKS_IN_HOUR (CLOCKS_IN_HOUR),
    .HOURS_PER_DAY  (HOURS_PER_DAY)
  ) u_timer (
    .clock     (clock),
    .reset     (reset),
    .hour_idx  (hour_idx_s),
    .hour_tick (hour_tick_s),
    .day_wrap  (day_wrap_s)
  );

  // Occupancy update: exits before entries so a same-class pair can swap a car
  // at full capacity; free space is then recomputed against next hour's capacity.
  always_comb begin
    uni_cap_now_s = cap_of(hour_idx_s);
    gen_cap_now_s = TOTAL_CAP_S - uni_cap_now_s;
    if (day_wrap_s) begin
      hour_next_s = {HOUR_W{1'b0}};
    end else if (hour_tick_s) begin
      hour_next_s = hour_idx_s + HOUR_W'(1'b1);
    end else begin
      hour_next_s = hour_idx_s;
    end
    uni_cap_next_s = cap_of(hour_next_s);
    gen_cap_next_s = TOTAL_CAP_S - uni_cap_next_s;

    uni_parked_d  = uni_parked_q;
    parked_d      = parked_q;
    ja_nist_d     = 1'b0;
    faulty_exit_d = 1'b0;

    if (car_exited && is_uni_car_exited) begin
      if (uni_parked_d != CNT_ZERO) uni_parked_d = uni_parked_d - CNT_ONE;
      else                          faulty_exit_d = 1'b1;
    end else if (car_exited) begin
      if (parked_d != CNT_ZERO) parked_d = parked_d - CNT_ONE;
      else                      faulty_exit_d = 1'b1;
    end else begin
      faulty_exit_d = 1'b0;
    end

    if (car_entered && is_uni_car_entered) begin
      if (free_of(uni_cap_now_s, uni_parked_d) != CNT_ZERO) uni_parked_d = uni_parked_d + CNT_ONE;
      else                                                  ja_nist_d = 1'b1;
    end else if (car_entered) begin
      if (free_of(gen_cap_now_s, parked_d) != CNT_ZERO) parked_d = parked_d + CNT_ONE;
      else                                              ja_nist_d = 1'b1;
    end else begin
      ja_nist_d = 1'b0;
    end

    if (day_wrap_s) begin
      uni_parked_d  = CNT_ZERO;
      parked_d      = CNT_ZERO;
      ja_nist_d     = 1'b0;
      faulty_exit_d = 1'b0;
    end else begin
      uni_parked_d  = uni_parked_d;
      parked_d      = parked_d;
    end

    uni_vac_d    = free_of(uni_cap_next_s, uni_parked_d);
    vac_d        = free_of(gen_cap_next_s, parked_d);
    uni_is_vac_d = (uni_vac_d != CNT_ZERO);
    is_vac_d     = (vac_d != CNT_ZERO);
    hour_d       = START_HOUR_V + hour_next_s;
  end

  // Output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hour_q        <= START_HOUR_V;
      uni_parked_q  <= CNT_ZERO;
      parked_q      <= CNT_ZERO;
      uni_vac_q     <= RST_UNI_VAC;
      vac_q         <= RST_GEN_VAC;
      uni_is_vac_q  <= 1'b1;
      is_vac_q      <= 1'b1;
      ja_nist_q     <= 1'b0;
      faulty_exit_q <= 1'b0;
    end else begin
      hour_q        <= hour_d;
      uni_parked_q  <= uni_parked_d;
      parked_q      <= parked_d;
      uni_vac_q     <= uni_vac_d;
      vac_q         <= vac_d;
      uni_is_vac_q  <= uni_is_vac_d;
      is_vac_q      <= is_vac_d;
      ja_nist_q     <= ja_nist_d;
      faulty_exit_q <= faulty_exit_d;
    end
  end

  assign hour                 = hour_q;
  assign uni_parked_car       = uni_parked_q;
  assign parked_car           = parked_q;
  assign uni_vacated_space    = uni_vac_q;
  assign vacated_space        = vac_q;
  assign uni_is_vacated_space = uni_is_vac_q;
  assign is_vacated_space     = is_vac_q;
  assign ja_nist              = ja_nist_q;
  assign faulty_exit          = faulty_exit_q;

`ifdef PARKING_PEAK_EN
  logic [CNT_W-1:0] uni_peak_d, uni_peak_q, gen_peak_d, gen_peak_q;

  // Daily high-water marks track the new counts and restart with the day.
  always_comb begin
    if (day_wrap_s) begin
      uni_peak_d = CNT_ZERO;
      gen_peak_d = CNT_ZERO;
    end else begin
      uni_peak_d = (uni_parked_d > uni_peak_q) ? uni_parked_d : uni_peak_q;
      gen_peak_d = (parked_d > gen_peak_q) ? parked_d : gen_peak_q;
    end
  end

  // Peak registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      uni_peak_q <= CNT_ZERO;
      gen_peak_q <= CNT_ZERO;
    end else begin
      uni_peak_q <= uni_peak_d;
      gen_peak_q <= gen_peak_d;
    end
  end

  assign uni_peak = uni_peak_q;
  assign gen_peak = gen_peak_q;
`else
  // Peak tracking is not built in this configuration.
`endif

endmodule

// File: doc/parking_ctrl_gen.md
Name: parking_ctrl_gen

Overview:
Parametrised second-generation parking controller for the campus lot. It keeps a time-of-day clock and counts university and general cars on entry and exit events. It computes vacant space per class from an hourly university-capacity schedule, flags rejected entries and faulty exits, and clears all occupancy when the day wraps. It drives the lot display and gate logic directly.

Parameters:
CLOCKS_IN_HOUR, 500, clock cycles per simulated hour
START_HOUR, 8, hour output value at hour index 0
HOURS_PER_DAY, 24, hour indices per day before the day wraps
TOTAL_CAP, 700, total spaces (university plus general)
UNI_CAP_BASE, 500, university capacity before the ramp starts
UNI_CAP_STEP, 50, university capacity lost per hour once the ramp is active
UNI_CAP_MIN, 200, floor on university capacity
RAMP_START, 5, first hour index at which the ramp applies
CNT_W, 10, width of all count outputs; must satisfy 2^CNT_W > TOTAL_CAP

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
car_entered  in  1  entry event this cycle
is_uni_car_entered  in  1  class of the entering car (1 = university)
car_exited  in  1  exit event this cycle
is_uni_car_exited  in  1  class of the exiting car (1 = university)
hour  out  5  START_HOUR + hour index
uni_parked_car  out  CNT_W  university cars parked
parked_car  out  CNT_W  general cars parked
uni_vacated_space  out  CNT_W  university spaces free
vacated_space  out  CNT_W  general spaces free
uni_is_vacated_space  out  1  uni_vacated_space != 0
is_vacated_space  out  1  vacated_space != 0
ja_nist  out  1  one-cycle pulse: entry rejected, no space in that class
faulty_exit  out  1  one-cycle pulse: exit with zero count in that class

Behaviour:
- Reset values: hour index 0 (hour = START_HOUR), cycle counter 0, both parked counts 0, uni_vacated_space = UNI_CAP_BASE, vacated_space = TOTAL_CAP - UNI_CAP_BASE, both is_* flags 1, both pulses 0.
- Timer: the cycle counter counts 0..CLOCKS_IN_HOUR-1. When it wraps, the hour index increments modulo HOURS_PER_DAY.
- Day wrap: on the edge where the hour index goes from HOURS_PER_DAY-1 to 0, all counts return to reset values. Events on that edge are dropped and raise no pulses.
- Capacity for hour index h: uni_cap = UNI_CAP_BASE if h < RAMP_START, otherwise max(UNI_CAP_MIN, UNI_CAP_BASE - UNI_CAP_STEP*(h-RAMP_START+1)). gen_cap = TOTAL_CAP - uni_cap. Computed in CNT_W+4 bits signed; no wrap is permitted.
- Free space: uni free = uni_cap - uni_parked, clamped at 0. General free = gen_cap - parked_car, clamped at 0. Shrinking capacity never evicts cars; it only blocks entries.
- Latency: all outputs are registered. An event sampled on edge N appears in the counts, vacated values and pulses after edge N. Vacated values reflect the new capacity on the same edge that the hour changes.
- Entry: accepted only if the class free space before the event is > 0; the count increments. Otherwise the count is unchanged and ja_nist pulses.
- Exit: accepted only if the class count before the event is > 0; the count decrements. Otherwise the count is unchanged and faulty_exit pulses.
- Simultaneous entry and exit, same class: the exit is evaluated first, then the entry against the updated free space. At full capacity with one car present, both are accepted and the net count is unchanged.
- Simultaneous entry and exit, different classes: the two are independent.
- Reset mid-hour restarts the timer at index 0 immediately.

Optional Feature:
PARKING_PEAK_EN: when defined, adds output uni_peak [CNT_W] and output gen_peak [CNT_W]. These hold the per-day maximum of each parked count, update in the same cycle as the count, and clear at reset and at day wrap. When not defined, neither port nor its logic exists.

Decomposition:
- Package parking_pkg holds CNT_W and hour-width localparams, the default capacity constants, and a function uni_cap_at(h) implementing the schedule.
- One sub-module, parking_hour_timer: parameters CLOCKS_IN_HOUR and HOURS_PER_DAY; outputs hour_idx, hour_tick and day_wrap pulses.
- Counting and capacity logic stays in parking_ctrl_gen.

Test Plan:
- Reset, then run with CLOCKS_IN_HOUR=4 -> hour goes 8,9,... every 4 cycles; uni_vacated_space=500, vacated_space=200.
- Hour index 5 with 450 uni parked -> uni cap 450, uni_vacated_space=0, uni_is_vacated_space=0; the next uni entry pulses ja_nist and the count stays 450.
- 200 general parked, then one general entry together with one general exit -> parked_car stays 200; no pulses.
- Uni exit with uni_parked_car=0 -> faulty_exit pulses for one cycle; count stays 0.
- 300 uni parked at hour index 8 (cap 300), advance to index 9 (cap 250) -> uni_vacated_space=0, count 300; entries rejected until the count falls below 250.
- Entries pending at the hour 23->0 edge -> all counts back to reset values and no pulses; reset asserted mid-hour -> hour=8 on the next cycle.
